// File: rtl/sequence_generator_moore.sv
// Serial pattern transmitter: loads a PATTERN_W-bit word and shifts it out MSB-first,
// repeated max(repeat_in,1) times, with optional idle gaps between repeats.
module sequence_generator_moore #(
   parameter int   PATTERN_W  = 4,
   parameter int   CNT_W      = 8,
   parameter int   GAP_CYCLES = 0,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [PATTERN_W-1:0] pattern_in,
   input  logic [CNT_W-1:0]     repeat_in,
   input  logic                 abort,
   output logic                 ready,
   output logic                 sequence_out,
   output logic                 out_valid,
   output logic                 last_bit,
   output logic                 done
);

   localparam int IDX_W = $clog2(PATTERN_W);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(PATTERN_W - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [PATTERN_W-1:0] pat_q, pat_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [CNT_W-1:0]     rep_q, rep_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic                 done_d, ready_d, valid_d, seq_d, last_d;

   // rep_q holds the repeats still to send, including the one in progress, so it
   // only ever counts down to one and cannot wrap.
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      idx_d   = idx_q;
      rep_d   = rep_q;
      gap_d   = gap_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               pat_d   = pattern_in;
               rep_d   = (repeat_in == '0) ? REP_ONE : repeat_in;
               idx_d   = IDX_MSB;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (idx_q != '0) begin
               idx_d = idx_q - IDX_ONE;
            end else if (rep_q == REP_ONE) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               rep_d = rep_q - REP_ONE;
               idx_d = IDX_MSB;
               if (GAP_CYCLES > 0) begin
                  state_d = S_GAP;
                  gap_d   = GAP_LOAD;
               end
            end
         end
         S_GAP: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (gap_q == '0) begin
               state_d = S_SHIFT;
            end else begin
               gap_d = gap_q - GAP_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they can be registered and
      // still line up with the state they describe.
      ready_d = (state_d == S_IDLE);
      valid_d = (state_d == S_SHIFT);
      seq_d   = valid_d ? pat_d[idx_d] : IDLE_LEVEL;
      last_d  = valid_d && (idx_d == '0) && (rep_d == REP_ONE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         pat_q        <= '0;
         idx_q        <= '0;
         rep_q        <= '0;
         gap_q        <= '0;
         ready        <= 1'b1;
         sequence_out <= IDLE_LEVEL;
         out_valid    <= 1'b0;
         last_bit     <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_q      <= state_d;
         pat_q        <= pat_d;
         idx_q        <= idx_d;
         rep_q        <= rep_d;
         gap_q        <= gap_d;
         ready        <= ready_d;
         sequence_out <= seq_d;
         out_valid    <= valid_d;
         last_bit     <= last_d;
         done         <= done_d;
      end
   end

endmodule

// File: tb/tb_sequence_generator_moore.sv
// Directed bench for sequence_generator_moore: a back-to-back instance and a
// two-cycle-gap instance driven from a vector table plus hand-written corner cases.
module tb_sequence_generator_moore;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start0 = 1'b0;
   logic       start1 = 1'b0;
   logic [3:0] pattern_in = '0;
   logic [7:0] repeat_in = '0;
   logic       abort = 1'b0;

   logic ready0, seq0, valid0, last0, done0;
   logic ready1, seq1, valid1, last1, done1;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   sequence_generator_moore #(.PATTERN_W(4), .CNT_W(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_gap0 (
      .clock(clock), .reset(reset), .start(start0), .pattern_in(pattern_in),
      .repeat_in(repeat_in), .abort(abort), .ready(ready0), .sequence_out(seq0),
      .out_valid(valid0), .last_bit(last0), .done(done0)
   );

   sequence_generator_moore #(.PATTERN_W(4), .CNT_W(8), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) u_gap2 (
      .clock(clock), .reset(reset), .start(start1), .pattern_in(pattern_in),
      .repeat_in(repeat_in), .abort(abort), .ready(ready1), .sequence_out(seq1),
      .out_valid(valid1), .last_bit(last1), .done(done1)
   );

   typedef struct {
      int          sel;
      logic [3:0]  pattern;
      logic [7:0]  rep;
      int          exp_len;
      logic [31:0] exp_stream;
      int          exp_span;
      int          exp_det;
   } vec_t;

   vec_t vecs[6];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Starts one transfer on the selected instance and records what comes out
   // until done (or a cycle budget runs out). With spam set, start stays high
   // and the pattern keeps changing while the transfer is busy.
   task automatic applyStimulus(input int sel, input logic [3:0] pat, input logic [7:0] rep,
                                input bit spam, output logic [31:0] stream, output int len,
                                output int span, output int lastcnt, output int lastpos,
                                output int det, output int idlebad, output logic rdy_at_done,
                                output bit got_done);
      logic       v, b, l, d, r;
      logic [3:0] det_sr;
      int         first;
      stream = '0; len = 0; span = -1; lastcnt = 0; lastpos = -1; det = 0; idlebad = 0;
      rdy_at_done = 1'b0; got_done = 1'b0; det_sr = '0; first = -1;
      @(negedge clock);
      pattern_in = pat;
      repeat_in  = rep;
      if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      for (int c = 0; c < 200 && !got_done; c++) begin
         @(negedge clock);
         if (spam) begin
            pattern_in = pattern_in + 4'd5;
            repeat_in  = repeat_in + 8'd3;
         end else begin
            start0 = 1'b0;
            start1 = 1'b0;
         end
         if (sel == 0) begin v = valid0; b = seq0; l = last0; d = done0; r = ready0; end
         else          begin v = valid1; b = seq1; l = last1; d = done1; r = ready1; end
         if (v) begin
            if (first < 0) first = c;
            stream = {stream[30:0], b};
            len++;
            det_sr = {det_sr[2:0], b};
            if (len >= 4 && det_sr == 4'b1011) det++;
         end else if (b !== 1'b0) begin
            idlebad++;
         end
         if (l) begin
            lastcnt++;
            lastpos = v ? len : -2;
         end
         if (d) begin
            got_done    = 1'b1;
            span        = c - first;
            rdy_at_done = r;
            start0      = 1'b0;
            start1      = 1'b0;
         end
      end
      start0 = 1'b0;
      start1 = 1'b0;
      if (!got_done) checkOutput("done_timeout", 32'(got_done), 32'd1);
   endtask

   initial begin
      logic [31:0] stream;
      int          len, span, lastcnt, lastpos, det, idlebad, cnt;
      logic        rdy;
      bit          got;
      bit          seen;

      vecs[0] = '{0, 4'b1011, 8'd1, 4,  32'hB,   4,  1};
      vecs[1] = '{0, 4'b1011, 8'd3, 12, 32'hBBB, 12, 3};
      vecs[2] = '{0, 4'b1011, 8'd0, 4,  32'hB,   4,  1};
      vecs[3] = '{0, 4'b0110, 8'd2, 8,  32'h66,  8,  0};
      vecs[4] = '{1, 4'b1011, 8'd2, 8,  32'hBB,  10, 2};
      vecs[5] = '{1, 4'b1001, 8'd1, 4,  32'h9,   4,  0};

      // Reset values, both while held and after release.
      repeat (2) @(negedge clock);
      checkOutput("rst_ready",  {30'd0, ready0, ready1}, 32'h3);
      checkOutput("rst_valid",  {30'd0, valid0, valid1}, 32'h0);
      checkOutput("rst_seq",    {30'd0, seq0, seq1},     32'h0);
      checkOutput("rst_last",   {30'd0, last0, last1},   32'h0);
      checkOutput("rst_done",   {30'd0, done0, done1},   32'h0);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("post_rst_ready", {31'd0, ready0}, 32'd1);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].sel, vecs[i].pattern, vecs[i].rep, 1'b0,
                       stream, len, span, lastcnt, lastpos, det, idlebad, rdy, got);
         checkOutput($sformatf("v%0d_stream", i), stream, vecs[i].exp_stream);
         checkOutput($sformatf("v%0d_len", i), 32'(len), 32'(vecs[i].exp_len));
         checkOutput($sformatf("v%0d_span", i), 32'(span), 32'(vecs[i].exp_span));
         checkOutput($sformatf("v%0d_lastcnt", i), 32'(lastcnt), 32'd1);
         checkOutput($sformatf("v%0d_lastpos", i), 32'(lastpos), 32'(vecs[i].exp_len));
         checkOutput($sformatf("v%0d_detect", i), 32'(det), 32'(vecs[i].exp_det));
         checkOutput($sformatf("v%0d_idle_level", i), 32'(idlebad), 32'd0);
         checkOutput($sformatf("v%0d_ready_at_done", i), {31'd0, rdy}, 32'd1);
         @(negedge clock);
         checkOutput($sformatf("v%0d_done_pulse", i),
                     {31'd0, (vecs[i].sel == 0) ? done0 : done1}, 32'd0);
      end

      // Abort on the second bit of the second repeat of three.
      @(negedge clock);
      pattern_in = 4'b1011; repeat_in = 8'd3; start0 = 1'b1;
      cnt = 0;
      for (int c = 0; c < 50 && cnt < 6; c++) begin
         @(negedge clock);
         start0 = 1'b0;
         if (valid0) cnt++;
      end
      checkOutput("abort_bits_before", 32'(cnt), 32'd6);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      checkOutput("abort_valid", {31'd0, valid0}, 32'd0);
      checkOutput("abort_ready", {31'd0, ready0}, 32'd1);
      checkOutput("abort_seq",   {31'd0, seq0},   32'd0);
      checkOutput("abort_done",  {31'd0, done0},  32'd0);
      applyStimulus(0, 4'b0110, 8'd1, 1'b0, stream, len, span, lastcnt, lastpos, det, idlebad, rdy, got);
      checkOutput("after_abort_stream", stream, 32'h6);
      checkOutput("after_abort_len", 32'(len), 32'd4);

      // start and abort together in IDLE: nothing starts.
      @(negedge clock);
      start0 = 1'b1; abort = 1'b1;
      @(negedge clock);
      start0 = 1'b0; abort = 1'b0;
      checkOutput("start_abort_ready", {31'd0, ready0}, 32'd1);
      checkOutput("start_abort_valid", {31'd0, valid0}, 32'd0);

      // start held high while busy, with a changing pattern.
      applyStimulus(0, 4'b1011, 8'd2, 1'b1, stream, len, span, lastcnt, lastpos, det, idlebad, rdy, got);
      checkOutput("spam_stream", stream, 32'hBB);
      checkOutput("spam_len", 32'(len), 32'd8);
      @(negedge clock);
      checkOutput("spam_no_restart", {30'd0, ready0, valid0}, 32'h2);

      // Async reset between edges in the middle of a transfer.
      @(negedge clock);
      pattern_in = 4'b1011; repeat_in = 8'd3; start0 = 1'b1;
      @(negedge clock);
      start0 = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("pre_reset_valid", {31'd0, valid0}, 32'd1);
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      checkOutput("async_rst_valid", {31'd0, valid0}, 32'd0);
      checkOutput("async_rst_ready", {31'd0, ready0}, 32'd1);
      checkOutput("async_rst_last",  {31'd0, last0},  32'd0);
      @(negedge clock);
      reset = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         if (done0 || valid0 || !ready0) seen = 1'b1;
      end
      checkOutput("after_reset_quiet", {31'd0, seen}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
